// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit with variable-latency memory and text-print handshakes and a sticky fault state.
// Optional feature: define MIPS_MC_IMMEXT_EN to decode andi/slti through the IMMEX state.
module mips_mc_ctrl #(
  parameter int unsigned NUM_TXT_CH = 2,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned CHW       = (NUM_TXT_CH > 1) ? $clog2(NUM_TXT_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic [CHW-1:0]        chsel,
  input  logic                  zero,
  input  logic                  mem_ready,
  input  logic [NUM_TXT_CH-1:0] txt_ready,
  output logic                  pcen,
  output logic                  memread,
  output logic                  memwrite,
  output logic                  irwrite,
  output logic                  regwrite,
  output logic                  alusrca,
  output logic                  iord,
  output logic                  memtoreg,
  output logic                  regdst,
  output logic                  jal,
  output logic [1:0]            pcsrc,
  output logic [2:0]            alusrcb,
  output logic [2:0]            alucontrol,
  output logic [NUM_TXT_CH-1:0] txt_valid,
  output logic                  fault,
  output logic [4:0]            state_dbg
);

  localparam int unsigned CW = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_TEXTP = 6'b101010;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [4:0] {
    FETCH   = 5'd0,  DECODE  = 5'd1,  MEMADR = 5'd2,  MEMRD  = 5'd3,
    MEMWB   = 5'd4,  MEMWR   = 5'd5,  RTYPEEX = 5'd6, RTYPEWB = 5'd7,
    BEQEX   = 5'd8,  ADDIEX  = 5'd9,  IWB    = 5'd10, JEX    = 5'd11,
    BNEEX   = 5'd12, ORIEX   = 5'd13, JALEX  = 5'd14, JREX   = 5'd15,
    TEXTEX  = 5'd16, FAULT   = 5'd17, IMMEX  = 5'd18
  } state_t;

  state_t          state, state_n, ostate;
  logic [CHW-1:0]  chsel_q;
  logic [CW-1:0]   wcnt;
  logic            waiting_c, rdy_c, tmo_c;
  logic            pcwrite_c, branch_c, brne_c;

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: rtype_alu = ALU_ADD;
    endcase
  endfunction

  // Ready input of the current wait state and timeout detection; ready beats timeout
  always_comb begin
    waiting_c = 1'b0;
    rdy_c     = 1'b1;
    case (state)
      FETCH, MEMRD, MEMWR: begin
        waiting_c = 1'b1;
        rdy_c     = mem_ready;
      end
      TEXTEX: begin
        waiting_c = 1'b1;
        rdy_c     = txt_ready[chsel_q];
      end
      default: ;
    endcase
    tmo_c = waiting_c && !rdy_c && (TIMEOUT != 0) && (wcnt == CW'(TIMEOUT));
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   if (tmo_c) state_n = FAULT; else if (mem_ready) state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE: begin
            case (funct)
              FN_JR:                                   state_n = JREX;
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:   state_n = RTYPEEX;
              default:                                 state_n = FAULT;
            endcase
          end
          OP_BEQ:   state_n = BEQEX;
          OP_BNE:   state_n = BNEEX;
          OP_ADDI:  state_n = ADDIEX;
          OP_ORI:   state_n = ORIEX;
          OP_J:     state_n = JEX;
          OP_JAL:   state_n = JALEX;
          OP_TEXTP: state_n = (32'(chsel) < NUM_TXT_CH) ? TEXTEX : FAULT;
`ifdef MIPS_MC_IMMEXT_EN
          OP_ANDI, OP_SLTI: state_n = IMMEX;
`else
          OP_ANDI, OP_SLTI: state_n = FAULT;
`endif
          default:  state_n = FAULT;
        endcase
      end
      MEMADR:  state_n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (tmo_c) state_n = FAULT; else if (mem_ready) state_n = MEMWB;
      MEMWR:   if (tmo_c) state_n = FAULT; else if (mem_ready) state_n = FETCH;
      TEXTEX:  if (tmo_c) state_n = FAULT; else if (rdy_c) state_n = FETCH;
      RTYPEEX: state_n = RTYPEWB;
      ADDIEX, ORIEX: state_n = IWB;
`ifdef MIPS_MC_IMMEXT_EN
      IMMEX:   state_n = IWB;
`else
      IMMEX:   state_n = FAULT;
`endif
      MEMWB, RTYPEWB, IWB, BEQEX, BNEEX, JEX, JALEX, JREX: state_n = FETCH;
      FAULT:   state_n = FAULT;
      default: state_n = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      wcnt    <= '0;
      chsel_q <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) chsel_q <= chsel;
      if (state_n != state)                              wcnt <= '0;
      else if (waiting_c && !rdy_c && wcnt != {CW{1'b1}}) wcnt <= wcnt + CW'(1);
    end
  end

  // Output decode; during reset the FETCH encoding is shown with all strobes gated off
  always_comb begin
    ostate     = reset ? state : FETCH;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    brne_c     = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    jal        = 1'b0;
    pcsrc      = 2'b00;
    alusrcb    = 3'b000;
    alucontrol = ALU_ADD;
    txt_valid  = '0;
    case (ostate)
      FETCH: begin
        memread   = 1'b1;
        alusrcb   = 3'b001;
        irwrite   = mem_ready;
        pcwrite_c = mem_ready;
      end
      DECODE:  alusrcb = 3'b011;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu(funct);
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
      end
      ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 3'b100;
        alucontrol = ALU_OR;
      end
`ifdef MIPS_MC_IMMEXT_EN
      IMMEX: begin
        alusrca = 1'b1;
        if (op == OP_SLTI) begin
          alusrcb    = 3'b010;
          alucontrol = ALU_SLT;
        end else begin
          alusrcb    = 3'b100;
          alucontrol = ALU_AND;
        end
      end
`endif
      IWB:     regwrite = 1'b1;
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch_c   = 1'b1;
        brne_c     = (ostate == BNEEX);
        pcsrc      = 2'b01;
      end
      JEX: begin
        pcwrite_c = 1'b1;
        pcsrc     = 2'b10;
      end
      JALEX: begin
        pcwrite_c = 1'b1;
        pcsrc     = 2'b10;
        jal       = 1'b1;
        regwrite  = 1'b1;
      end
      JREX: begin
        pcwrite_c = 1'b1;
        pcsrc     = 2'b11;
      end
      TEXTEX:  txt_valid = NUM_TXT_CH'(1) << chsel_q;
      default: ;
    endcase
    pcen = pcwrite_c | (branch_c & (zero ^ brne_c));
    if (!reset) begin
      pcen      = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      memread   = 1'b0;
      txt_valid = '0;
    end
  end

  assign fault     = reset && (state == FAULT);
  assign state_dbg = state;

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Parametrised multicycle MIPS control unit with variable-latency memory handshakes, multi-channel text-print handshakes and a sticky fault state. It sits between the instruction/data fields of the multicycle datapath and its enables and muxes. It replaces the fixed-latency controller: every memory access waits on `mem_ready`, and each print instruction waits on the selected channel's `txt_ready`.

## Interface
- `NUM_TXT_CH`, default 2: number of text-print channels (1..8). `CHW = (NUM_TXT_CH>1) ? $clog2(NUM_TXT_CH) : 1`.
- `TIMEOUT`, default 255: maximum wait cycles in any handshake state. 0 disables the timeout. Counter is 16 bits wide.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `op` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `chsel` in CHW: text channel select, instr[16+CHW-1:16] (rt field).
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: current memory access completes this cycle.
- `txt_ready` in NUM_TXT_CH: per-channel sink accepts a character.
- `pcen`, `memread`, `memwrite`, `irwrite`, `regwrite` out 1 each.
- `alusrca`, `iord`, `memtoreg`, `regdst`, `jal` out 1 each.
- `pcsrc` out 2: 00 aluresult, 01 aluout, 10 jump target, 11 rd1.
- `alusrcb` out 3: 000 B, 001 const 4, 010 signimm, 011 signimm<<2, 1xx zeroimm.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `txt_valid` out NUM_TXT_CH: one-hot print request.
- `fault` out 1: sticky error flag.
- `state_dbg` out 5: current state encoding.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IWB 10, JEX 11, BNEEX 12, ORIEX 13, JALEX 14, JREX 15, TEXTEX 16, FAULT 17, IMMEX 18.
- FETCH: `memread`=1, iord=0, alusrca=0, alusrcb=001, pcsrc=00, aluop add. When `mem_ready`=1, `irwrite` and pcwrite pulse that cycle and the block moves to DECODE. Otherwise it stays in FETCH.
- DECODE: alusrcb=011, add. Next state by opcode:
  - lw 100011 and sw 101011 → MEMADR.
  - R-type 000000: funct 001000 → JREX; funct in {100000, 100010, 100100, 100101, 101010} → RTYPEEX; any other funct → FAULT.
  - beq 000100 → BEQEX; bne 000101 → BNEEX.
  - addi 001000 → ADDIEX; ori 001101 → ORIEX.
  - j 000010 → JEX; jal 000011 → JALEX.
  - textp 101010 → TEXTEX if chsel < NUM_TXT_CH, else FAULT.
  - Any other opcode → FAULT.
- MEMADR: alusrca=1, alusrcb=010, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `memread`=1, iord=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWR: `memwrite`=1, iord=1. Holds until `mem_ready`, then goes to FETCH. `memwrite` is held level for the whole wait.
- MEMWB: regwrite, memtoreg. RTYPEEX: alusrca=1, alusrcb=000, alucontrol from funct. RTYPEWB: regwrite, regdst.
- ADDIEX: alusrca=1, alusrcb=010, add. ORIEX: alusrcb=100, or. IWB: regwrite.
- BEQEX/BNEEX: alusrca=1, sub, branch=1, pcsrc=01. bne inverts the zero test: `pcen = pcwrite | branch & (zero ^ bne)`.
- JEX: pcwrite, pcsrc=10. JALEX: pcwrite, pcsrc=10, jal=1, regwrite. JREX: pcwrite, pcsrc=11.
- TEXTEX: `txt_valid[chsel]`=1 and all other bits 0. Holds until `txt_ready[chsel]`, then goes to FETCH. `chsel` is sampled in DECODE and registered, so later changes on the input are ignored.
- Wait counter:
  - Cleared on entry to any wait state (FETCH, MEMRD, MEMWR, TEXTEX).
  - Increments each cycle the state's ready input is low.
  - When the count reaches TIMEOUT with ready still low, next state is FAULT.
  - Ready arriving in the same cycle as the count reaching TIMEOUT: ready wins.
- FAULT: all enables, `memread` and `txt_valid` are 0, and `fault`=1. Only reset leaves FAULT.

## Timing
- Reset: while `reset`=0, the next edge forces FETCH, clears the counter and clears `fault`.
- While `reset`=0, `pcen`, `irwrite`, `regwrite`, `memwrite`, `memread`, `txt_valid` and `fault` are forced to 0 combinationally. Other outputs follow the FETCH encoding.
- Reset asserted mid-wait abandons the access. No write strobe occurs after the reset edge.
- Outputs are a combinational function of the registered state plus the ready inputs. There are no extra pipeline stages.
- Zero-wait latencies in cycles: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j/jal/jr 3, textp 3. Each wait cycle on a ready input adds one cycle.

## Configuration
- `MIPS_MC_IMMEXT_EN`:
  - Defined: andi 001100 and slti 001010 decode to IMMEX. IMMEX sets alusrca=1 and uses the ALU result as follows:
    - andi: alusrcb=100, and.
    - slti: alusrcb=010, slt.
    
    IMMEX then goes to IWB, giving 4-cycle latency.
  - Undefined: both opcodes go to FAULT, and IMMEX is never reached.

## Test plan
- Zero-wait lw, `mem_ready` tied high → state sequence 0,1,2,3,4,0; one `regwrite` pulse with memtoreg=1 in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEMWR → `memwrite` high for exactly 4 cycles, then FETCH; no `regwrite`.
- textp with chsel=1, NUM_TXT_CH=2, `txt_ready`=2'b00 for 2 cycles then 2'b10 → `txt_valid`=2'b10 for 3 cycles, never 2'b01.
- TIMEOUT=4, `mem_ready` stuck low in FETCH → FAULT on the 5th edge with `fault`=1; all enables stay 0 until `reset`=0 for 1 cycle, then FETCH.
- beq with zero=1 → `pcen`=1 in BEQEX; bne with zero=1 → `pcen`=0; opcode 111111 → FAULT directly from DECODE.
- With `MIPS_MC_IMMEXT_EN` defined, andi → IMMEX with alusrcb=100 and alucontrol=000, then IWB. Without the macro, the same opcode → FAULT.
